trace_emitter: RTL and testbench
================================

// Module: trace_emitter
// PURPOSE
//  Hardware counterpart of the bench-side cycle monitor: samples CPU pipeline state each
//  clock (PC, stall/flush events) and transmits one framed trace record per cycle over a
//  valid/ready word stream for an off-chip logger. Sits beside CPU; inputs tap PC, hazard, control.
// PARAMETERS
//  DEPTH  4   records buffered between sampler and serializer; power of 2, >=2
//  CNT_W  16  width of cycle/stall/flush counters; 1..16, zero-extended into 16-bit fields
// PORTS
//  clk_i          in   1   clock; all state on rising edge
//  rst_i          in   1   asynchronous, active-low reset
//  start_i        in   1   sampling enable; a record is taken every cycle it is 1
//  pc_i           in   32  current PC (PC.pc_o)
//  stall_i        in   1   hazard-unit stall
//  branch_i       in   1   control branch; a stall with branch_i=1 is not counted
//  flush_i        in   1   IF/ID flush
//  rd_we_i        in   1   MEM/WB RegWrite (used only with TRACE_WB_EN)
//  rd_addr_i      in   5   MEM/WB rd address (used only with TRACE_WB_EN)
//  rd_data_i      in   32  writeback data (used only with TRACE_WB_EN)
//  trace_ready_i  in   1   sink ready
//  trace_valid_o  out  1   word valid
//  trace_data_o   out  32  trace word
//  trace_last_o   out  1   final word of record
// BEHAVIOUR
//  Reset (async, rst_i=0): valid/last/data=0, all counters 0, FIFO empty, ovf_pending=0, FSM IDLE.
//  Counters (only while start_i=1): cyc wraps mod 2^CNT_W; stl +1 when stall_i&!branch_i,
//   flu +1 when flush_i; stl/flu saturate at all-ones. start_i=0: counters hold, no record.
//  Record for cycle N: cycle field = cyc before increment (first record 0); stl/flu fields
//   include cycle N's own event. Pushed into FIFO at the edge ending cycle N.
//  Words: W0 header [31]=ovf, [30:16]=0 (see CONFIGURATION), [15:0]=cyc;
//   W1 {stl[15:0],flu[15:0]}; W2 pc. Last word asserts trace_last_o.
//  FSM: IDLE -> HDR -> CNT -> PC (-> WB) -> IDLE or HDR. IDLE pops FIFO when non-empty and
//   enters HDR; each state holds valid+data stable until valid&ready, then advances.
//   After last-word handshake: pop next record, go HDR same edge (no bubble) if FIFO
//   non-empty, else IDLE. First word of a record into empty pipe is valid after 2nd edge.
//  Full: push with FIFO full and no same-edge pop -> record dropped, ovf_pending set; push
//   while full with same-edge pop succeeds. Next successfully pushed record carries
//   ovf=ovf_pending; ovf_pending cleared on that push. Counters advance regardless of drop.
//  Pointers wrap mod DEPTH; full/empty via extra pointer MSB.
//  start_i deassert mid-record: queued records drain completely; no truncation.
//  Reset mid-word: valid drops immediately; partial record is lost, not resumed.
//  ready_i may toggle freely; valid never deasserts without a handshake (except reset).
// CONFIGURATION
//  TRACE_WB_EN defined: record has 4 words; header [30]=rd_we_i, [29:25]=rd_addr_i
//   sampled same cycle; W3 = rd_data_i (0 if rd_we_i=0), W3 carries last; FSM uses WB.
//  Undefined: 3 words, header [30:25]=0, W2 carries last, WB state and rd_* ports unused.
// STRUCTURE
//  trace_pkg: FSM state enum, word-index constants, header bit positions (OVF=31, WBV=30,
//   RD_HI=29, RD_LO=25), record struct type. Sub-module trace_fifo (DEPTH x record,
//   push/pop/full/empty, simultaneous push+pop when full); counters and FSM in top.
// TESTING
//  1 rst_i=0 mid-run, start_i=1 -> valid_o=0 at once; after release first header cyc=0.
//  2 one-cycle start_i, pc_i=0x4, ready_i=1 -> 0x00000000, 0x00000000, 0x00000004 (last).
//  3 cycle0 stall&branch, cycle1 stall only, cycle2 flush -> W1 0x0, 0x00010000, 0x00010001.
//  4 ready_i=0, start_i=1 cycles 0..9, DEPTH=4 -> records 0..4 delivered, 5..9 dropped;
//    after start_i low and ready_i=1: 5 records, cycle fields 0..4, ovf=0 on all.
//  5 same as 4 but start_i held to cycle 12, ready_i=1 at cycle 10 -> first post-drop
//    record has header[31]=1, cycle field >=10; later headers ovf=0.
//  6 TRACE_WB_EN, rd_we=1, rd_addr=5, rd_data=0xDEADBEEF cycle0 -> header 0x4A000000,
//    W3=0xDEADBEEF with last; without macro header 0x00000000, last on W2.

Source files
------------

// File: rtl/trace_pkg.sv
// trace_pkg: shared types and constants for the trace emitter.
//   state_e      serializer FSM states
//   WORD_*       word index of each field within a record
//   HDR_*        bit positions inside the header word
//   trace_rec_t  one sampled pipeline record as it sits in the FIFO
//   hdr_word()   packs a record's header word
// Optional feature macro: TRACE_WB_EN (adds writeback fields and a fourth word).
package trace_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_CNT  = 3'd2,
    ST_PC   = 3'd3,
    ST_WB   = 3'd4
  } state_e;

  localparam int unsigned WORD_HDR = 0;
  localparam int unsigned WORD_CNT = 1;
  localparam int unsigned WORD_PC  = 2;
  localparam int unsigned WORD_WB  = 3;

  localparam int unsigned HDR_OVF   = 31;
  localparam int unsigned HDR_WBV   = 30;
  localparam int unsigned HDR_RD_HI = 29;
  localparam int unsigned HDR_RD_LO = 25;

  // Counter fields are already zero-extended to 16 bits; rd_* stay zero
  // when the writeback extension is compiled out.
  typedef struct packed {
    logic        ovf;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [15:0] cyc;
    logic [15:0] stl;
    logic [15:0] flu;
    logic [31:0] pc;
    logic [31:0] rd_data;
  } trace_rec_t;

  function automatic logic [31:0] hdr_word(input trace_rec_t r);
    logic [31:0] w;
    w                        = '0;
    w[HDR_OVF]               = r.ovf;
    w[HDR_WBV]               = r.rd_we;
    w[HDR_RD_HI:HDR_RD_LO]   = r.rd_addr;
    w[15:0]                  = r.cyc;
    return w;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: DEPTH-entry record FIFO between the sampler and the serializer.
//   clk_i, rst_i   clock, asynchronous active-low reset
//   push_i, wdata_i  write request and record; ignored when full unless popping
//   pop_i, rdata_o   read request and head record (combinational from the head slot)
//   full_o, empty_o  status from pointer comparison
// Pointers carry one extra MSB so full and empty are distinguishable.
// A push while full is accepted when a pop happens on the same edge.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  trace_rec_t wdata_i,
  input  logic       pop_i,
  output trace_rec_t rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  trace_rec_t    mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          push_ok;
  logic          pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers define which slots are meaningful.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/trace_emitter.sv
// trace_emitter: samples CPU pipeline state every enabled cycle and serializes
// one framed record per cycle onto a valid/ready 32-bit word stream.
//   clk_i, rst_i             clock, asynchronous active-low reset
//   start_i                  sampling enable; one record per cycle while high
//   pc_i                     current PC
//   stall_i, branch_i        stall counted only when branch_i is low
//   flush_i                  IF/ID flush
//   rd_we_i, rd_addr_i, rd_data_i  MEM/WB writeback (used only with TRACE_WB_EN)
//   trace_ready_i            sink ready
//   trace_valid_o, trace_data_o, trace_last_o  word stream out
// Words: header {ovf, wbv, rd_addr, 0, cyc}, {stl, flu}, pc [, rd_data].
// Optional feature macro: TRACE_WB_EN (4-word records with writeback info).
//
// state   | meaning
// IDLE    | no record in flight; pops the FIFO when it has a record
// HDR     | presenting header word
// CNT     | presenting {stall, flush} counter word
// PC      | presenting PC word (last word unless TRACE_WB_EN)
// WB      | presenting writeback data word (TRACE_WB_EN only, last word)
module trace_emitter
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic        flush_i,
  input  logic        rd_we_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i,
  input  logic        trace_ready_i,
  output logic        trace_valid_o,
  output logic [31:0] trace_data_o,
  output logic        trace_last_o
);

  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] stl_q, stl_d;
  logic [CNT_W-1:0] flu_q, flu_d;
  logic             ovf_pending_q, ovf_pending_d;
  state_e           state_q, state_d;
  trace_rec_t       cur_q, cur_d;
  trace_rec_t       rec_in;
  trace_rec_t       fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             push_accept;

  // ---------------------------------------------------------------- counters
  always_comb begin
    cyc_d = cyc_q;
    stl_d = stl_q;
    flu_d = flu_q;
    if (start_i) begin
      cyc_d = cyc_q + CNT_W'(1);
      if (stall_i && !branch_i && (stl_q != '1)) stl_d = stl_q + CNT_W'(1);
      if (flush_i && (flu_q != '1))              flu_d = flu_q + CNT_W'(1);
    end
  end

  // A record whose push is refused is lost; the flag rides on the next
  // record that does make it into the FIFO.
  assign push_accept = !fifo_full || fifo_pop;

  always_comb begin
    ovf_pending_d = ovf_pending_q;
    if (start_i) ovf_pending_d = !push_accept;
  end

  // Cycle field is the pre-increment count; event counters include this
  // cycle's own stall/flush.
  always_comb begin
    rec_in         = '0;
    rec_in.ovf     = ovf_pending_q;
    rec_in.cyc     = 16'(cyc_q);
    rec_in.stl     = 16'(stl_d);
    rec_in.flu     = 16'(flu_d);
    rec_in.pc      = pc_i;
`ifdef TRACE_WB_EN
    rec_in.rd_we   = rd_we_i;
    rec_in.rd_addr = rd_addr_i;
    rec_in.rd_data = rd_we_i ? rd_data_i : 32'h0;
`endif
  end

`ifndef TRACE_WB_EN
  logic unused_rd;
  assign unused_rd = ^{rd_we_i, rd_addr_i, rd_data_i, cur_q.rd_data};
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cyc_q         <= '0;
      stl_q         <= '0;
      flu_q         <= '0;
      ovf_pending_q <= 1'b0;
    end else begin
      cyc_q         <= cyc_d;
      stl_q         <= stl_d;
      flu_q         <= flu_d;
      ovf_pending_q <= ovf_pending_d;
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (start_i),
    .wdata_i (rec_in),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // --------------------------------------------------------------- serializer
  always_comb begin
    state_d       = state_q;
    fifo_pop      = 1'b0;
    trace_valid_o = 1'b0;
    trace_data_o  = 32'h0;
    trace_last_o  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_HDR;
        end
      end
      ST_HDR: begin
        trace_valid_o = 1'b1;
        trace_data_o  = hdr_word(cur_q);
        if (trace_ready_i) state_d = ST_CNT;
      end
      ST_CNT: begin
        trace_valid_o = 1'b1;
        trace_data_o  = {cur_q.stl, cur_q.flu};
        if (trace_ready_i) state_d = ST_PC;
      end
      ST_PC: begin
        trace_valid_o = 1'b1;
        trace_data_o  = cur_q.pc;
`ifdef TRACE_WB_EN
        if (trace_ready_i) state_d = ST_WB;
`else
        trace_last_o  = 1'b1;
        // Chain straight into the next record when one is waiting.
        if (trace_ready_i) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_HDR;
          end else begin
            state_d  = ST_IDLE;
          end
        end
`endif
      end
      ST_WB: begin
`ifdef TRACE_WB_EN
        trace_valid_o = 1'b1;
        trace_data_o  = cur_q.rd_data;
        trace_last_o  = 1'b1;
        if (trace_ready_i) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_HDR;
          end else begin
            state_d  = ST_IDLE;
          end
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cur_d = cur_q;
    if (fifo_pop) cur_d = fifo_head;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
    end
  end

endmodule

// File: tb/tb_trace_emitter.sv
module tb_trace_emitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] pc;
  logic        stall;
  logic        branch;
  logic        flush;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        ready;
  logic        valid;
  logic [31:0] data;
  logic        last;

  always #5 clk = ~clk;

  trace_emitter #(
    .DEPTH (4),
    .CNT_W (16)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .start_i       (start),
    .pc_i          (pc),
    .stall_i       (stall),
    .branch_i      (branch),
    .flush_i       (flush),
    .rd_we_i       (rd_we),
    .rd_addr_i     (rd_addr),
    .rd_data_i     (rd_data),
    .trace_ready_i (ready),
    .trace_valid_o (valid),
    .trace_data_o  (data),
    .trace_last_o  (last)
  );

  // {last, data} of each expected word, in order
  logic [32:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic exp_rec(input bit ovf, input int cyc, input int stl, input int flu,
                         input logic [31:0] pcv, input bit we, input logic [4:0] a,
                         input logic [31:0] d);
    logic [31:0] h;
    logic [15:0] c16, s16, f16;
    c16 = cyc[15:0];
    s16 = stl[15:0];
    f16 = flu[15:0];
    h = {ovf, 15'h0, c16};
`ifdef TRACE_WB_EN
    h[30]    = we;
    h[29:25] = a;
    exp_q.push_back({1'b0, h});
    exp_q.push_back({1'b0, s16, f16});
    exp_q.push_back({1'b0, pcv});
    exp_q.push_back({1'b1, (we ? d : 32'h0)});
`else
    exp_q.push_back({1'b0, h});
    exp_q.push_back({1'b0, s16, f16});
    exp_q.push_back({1'b1, pcv});
    if (we && (a != 5'd0) && (d == 32'h0)) h = '0;
`endif
  endtask

  // Monitor: compares each handshaken word against the scoreboard and checks
  // that a stalled word stays put until accepted.
  bit          prev_hold = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;

  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && prev_hold) begin
        n_tests++;
        if (!valid || data !== prev_data || last !== prev_last) begin
          n_fail++;
          $display("FAIL hold: got v=%0b d=0x%08h l=%0b expected v=1 d=0x%08h l=%0b",
                   valid, data, last, prev_data, prev_last);
        end
      end
      if (rst_n && valid && ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word: got d=0x%08h l=%0b expected no word", data, last);
        end else begin
          e = exp_q.pop_front();
          if (data !== e[31:0] || last !== e[32]) begin
            n_fail++;
            $display("FAIL word: got d=0x%08h l=%0b expected d=0x%08h l=%0b",
                     data, last, e[31:0], e[32]);
          end
        end
      end
      prev_hold = rst_n && valid && !ready;
      prev_data = data;
      prev_last = last;
    end
  end

  task automatic idle_inputs();
    start   = 1'b0;
    pc      = 32'h0;
    stall   = 1'b0;
    branch  = 1'b0;
    flush   = 1'b0;
    rd_we   = 1'b0;
    rd_addr = 5'd0;
    rd_data = 32'h0;
  endtask

  // Leaves the bench at posedge+1 with reset released: the start of cycle 0.
  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    ready = 1'b0;
    repeat (2) @(posedge clk);
    exp_q.delete();
    #1 rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 0;
    ready  = 1'b1;
    while ((exp_q.size() != 0 || valid) && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check({name, "_idle"}, {31'h0, valid}, 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    ready = 1'b0;
    idle_inputs();

    // Reset state
    do_reset();
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_data", data, 32'h0);
    check("rst_last", {31'h0, last}, 32'h0);

    // Test 1: reset mid-word drops valid immediately
    start = 1'b1;
    pc    = 32'h40;
    repeat (3) next_cycle();
    check("t1_valid_before", {31'h0, valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_valid_async", {31'h0, valid}, 32'h0);
    check("t1_data_async", data, 32'h0);
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Test 2: single record after release, latency to first word
    exp_rec(1'b0, 0, 0, 0, 32'h4, 1'b0, 5'd0, 32'h0);
    start = 1'b1;
    pc    = 32'h4;
    ready = 1'b1;
    next_cycle();
    start = 1'b0;
    @(negedge clk);
    check("t2_lat_edge1", {31'h0, valid}, 32'h0);
    @(negedge clk);
    check("t2_lat_edge2", {31'h0, valid}, 32'h1);
    drain("t2");

    // Test 3: stall-with-branch ignored, stall and flush counted
    do_reset();
    ready = 1'b1;
    exp_rec(1'b0, 0, 0, 0, 32'h100, 1'b0, 5'd0, 32'h0);
    exp_rec(1'b0, 1, 1, 0, 32'h104, 1'b0, 5'd0, 32'h0);
    exp_rec(1'b0, 2, 1, 1, 32'h108, 1'b0, 5'd0, 32'h0);
    start = 1'b1; pc = 32'h100; stall = 1'b1; branch = 1'b1; flush = 1'b0;
    next_cycle();
    pc = 32'h104; stall = 1'b1; branch = 1'b0; flush = 1'b0;
    next_cycle();
    pc = 32'h108; stall = 1'b0; branch = 1'b0; flush = 1'b1;
    next_cycle();
    idle_inputs();
    drain("t3");

    // Test 4: sink blocked, 10 records offered, only 5 survive
    do_reset();
    for (int i = 0; i < 5; i++) exp_rec(1'b0, i, 0, 0, 32'h1000 + 32'(4 * i), 1'b0, 5'd0, 32'h0);
    ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      start = 1'b1;
      pc    = 32'h1000 + 32'(4 * i);
      next_cycle();
    end
    idle_inputs();
    drain("t4");

    // Test 5: drops followed by a record that carries the overflow flag
    do_reset();
    for (int i = 0; i < 5; i++) exp_rec(1'b0, i, 0, 0, 32'h2000 + 32'(4 * i), 1'b0, 5'd0, 32'h0);
    exp_rec(1'b1, 12, 0, 0, 32'h2000 + 32'(4 * 12), 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 13; i++) begin
      start = 1'b1;
      pc    = 32'h2000 + 32'(4 * i);
      ready = (i >= 10);
      next_cycle();
    end
    idle_inputs();
    drain("t5");

    // Test 6: writeback fields (header bits and fourth word when enabled)
    do_reset();
    ready = 1'b1;
    exp_rec(1'b0, 0, 0, 0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
    exp_rec(1'b0, 1, 0, 0, 32'h8, 1'b0, 5'd0, 32'h12345678);
    start = 1'b1; pc = 32'h0; rd_we = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEADBEEF;
    next_cycle();
    pc = 32'h8; rd_we = 1'b0; rd_addr = 5'd0; rd_data = 32'h12345678;
    next_cycle();
    idle_inputs();
    drain("t6");

    // Test 7: sink ready toggling while records stream back to back
    do_reset();
    exp_rec(1'b0, 0, 1, 0, 32'h300, 1'b0, 5'd0, 32'h0);
    exp_rec(1'b0, 1, 1, 1, 32'h304, 1'b0, 5'd0, 32'h0);
    exp_rec(1'b0, 2, 2, 2, 32'h308, 1'b0, 5'd0, 32'h0);
    exp_rec(1'b0, 3, 2, 2, 32'h30C, 1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 40; k++) begin
      ready = ((k % 3) != 1);
      idle_inputs();
      case (k)
        0: begin start = 1'b1; pc = 32'h300; stall = 1'b1; end
        1: begin start = 1'b1; pc = 32'h304; flush = 1'b1; end
        2: begin start = 1'b1; pc = 32'h308; stall = 1'b1; flush = 1'b1; end
        3: begin start = 1'b1; pc = 32'h30C; stall = 1'b1; branch = 1'b1; end
        default: ;
      endcase
      next_cycle();
    end
    idle_inputs();
    drain("t7");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
